// File: rtl/prbs8_checker.sv
// Serial PRBS8 checker: self-synchronises to s[n] = s[n-4]^s[n-5]^s[n-6]^s[n-8],
// then counts checked bits and mispredictions, dropping lock after a run of errors.
module prbs8_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(UNLOCK_ERRS - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           r_state;
  logic [7:0]       r_hist;
  logic [3:0]       r_fill;
  logic [MW-1:0]    r_match;
  logic [EW-1:0]    r_err_run;
  logic             r_locked;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_bit_count;

  logic w_pred;
  logic w_miss;
  logic w_chk;
  logic w_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] v,
                                                  input logic clr, input logic hit);
    if (clr)
      return CNT_W'(hit);
    else if (hit)
      return sat_inc(v);
    else
      return v;
  endfunction

  assign w_pred = r_hist[7] ^ r_hist[5] ^ r_hist[4] ^ r_hist[3];
  assign w_miss = in_bit ^ w_pred;
  assign w_chk  = in_valid && (r_state == LOCKED);
  assign w_err  = w_chk && w_miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_hist      <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_err_run   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_bit_count <= '0;
    end else begin
      r_err_pulse <= w_err;
      r_bit_count <= next_count(r_bit_count, clear_counts, w_chk);
      r_err_count <= next_count(r_err_count, clear_counts, w_err);
      if (in_valid) begin
        case (r_state)
          SEARCH: begin
            r_hist <= {r_hist[6:0], in_bit};
            if (r_fill != 4'd8) begin
              r_fill <= r_fill + 4'd1;
            end else if (w_miss) begin
              r_match <= '0;
            end else if (r_hist != 8'h00) begin
              // An all-zero history trivially predicts zeros; never let it lock.
              if (r_match == MATCH_LAST) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_match  <= '0;
              end else begin
                r_match <= r_match + 1'b1;
              end
            end
          end
          LOCKED: begin
            // Feed back the prediction so a corrupted input bit cannot poison history.
            r_hist <= {r_hist[6:0], w_pred};
            if (!w_miss) begin
              r_err_run <= '0;
            end else if (r_err_run == ERR_LAST) begin
              r_state   <= SEARCH;
              r_locked  <= 1'b0;
              r_fill    <= '0;
              r_match   <= '0;
              r_err_run <= '0;
            end else begin
              r_err_run <= r_err_run + 1'b1;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: lock, single/burst errors, clears, gaps,
// degenerate input, saturation and reset priority.
module tb_prbs8_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear_counts = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] bit_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] g;

  prbs8_checker #(.LOCK_COUNT(16), .UNLOCK_ERRS(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear_counts(clear_counts), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  // Reference generator: Fibonacci LFSR emitting bit 0, feedback b0^b2^b3^b4.
  task automatic gen(output logic b);
    b = g[0];
    g = {g[0] ^ g[2] ^ g[3] ^ g[4], g[7:1]};
  endtask

  task automatic step(input logic v, input logic b, input logic clr);
    in_valid = v; in_bit = b; clear_counts = clr;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic flip, input logic clr);
    logic b;
    gen(b);
    step(1'b1, b ^ flip, clr);
  endtask

  task automatic test_reset;
    reset = 1'b1; step(1'b1, 1'b1, 1'b0); reset = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b exp 0", locked); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %0b exp 0", err_pulse); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_errcnt got %0d exp 0", err_count); end
    checks++; if (bit_count !== 16'd0) begin errors++; $display("FAIL reset_bitcnt got %0d exp 0", bit_count); end
  endtask

  task automatic test_clean_lock;
    logic early = 1'b0, pulse = 1'b0;
    g = 8'h6a;
    for (int i = 0; i < 23; i++) begin send(1'b0, 1'b0); if (locked !== 1'b0) early = 1'b1; end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL lock_early got 1 exp 0"); end
    send(1'b0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_at_24 got %0b exp 1", locked); end
    for (int i = 0; i < 255; i++) begin send(1'b0, 1'b0); if (err_pulse !== 1'b0) pulse = 1'b1; end
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL clean_pulse got 1 exp 0"); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_errcnt got %0d exp 0", err_count); end
    checks++; if (bit_count !== 16'd255) begin errors++; $display("FAIL clean_bitcnt got %0d exp 255", bit_count); end
  endtask

  task automatic test_single_error;
    logic pulse = 1'b0, drop = 1'b0;
    send(1'b1, 1'b0);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got %0b exp 1", err_pulse); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_errcnt got %0d exp 1", err_count); end
    for (int i = 0; i < 100; i++) begin
      send(1'b0, 1'b0);
      if (err_pulse !== 1'b0) pulse = 1'b1;
      if (locked !== 1'b1) drop = 1'b1;
    end
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL single_followon got 1 exp 0"); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL single_lockdrop got 1 exp 0"); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_errcnt_after got %0d exp 1", err_count); end
    checks++; if (bit_count !== 16'd356) begin errors++; $display("FAIL single_bitcnt got %0d exp 356", bit_count); end
  endtask

  task automatic test_burst;
    logic early = 1'b0;
    send(1'b0, 1'b1);
    checks++; if (bit_count !== 16'd1 || err_count !== 16'd0) begin errors++; $display("FAIL clear_clean got bits %0d errs %0d exp 1 0", bit_count, err_count); end
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL burst_3_locked got %0b exp 1", locked); end
    send(1'b1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL burst_4_locked got %0b exp 0", locked); end
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL burst_4_pulse got %0b exp 1", err_pulse); end
    checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL burst_errcnt got %0d exp 4", err_count); end
    checks++; if (bit_count !== 16'd5) begin errors++; $display("FAIL burst_bitcnt got %0d exp 5", bit_count); end
    for (int i = 0; i < 23; i++) begin send(1'b0, 1'b0); if (locked !== 1'b0) early = 1'b1; end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL relock_early got 1 exp 0"); end
    checks++; if (bit_count !== 16'd5) begin errors++; $display("FAIL search_bitcnt got %0d exp 5", bit_count); end
    send(1'b0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_24 got %0b exp 1", locked); end
  endtask

  task automatic test_clear_priority;
    send(1'b1, 1'b1);
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL clrerr_errcnt got %0d exp 1", err_count); end
    checks++; if (bit_count !== 16'd1) begin errors++; $display("FAIL clrerr_bitcnt got %0d exp 1", bit_count); end
    checks++; if (err_pulse !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL clrerr_flags got pulse %0b lock %0b exp 1 1", err_pulse, locked); end
    step(1'b0, 1'b1, 1'b1);
    checks++; if (err_count !== 16'd0 || bit_count !== 16'd0) begin errors++; $display("FAIL clr_idle got errs %0d bits %0d exp 0 0", err_count, bit_count); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL clr_idle_pulse got %0b exp 0", err_pulse); end
  endtask

  task automatic test_valid_low;
    logic pulse = 1'b0;
    send(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin step(1'b0, 1'(i), 1'b0); if (err_pulse !== 1'b0) pulse = 1'b1; end
    checks++; if (bit_count !== 16'd1 || err_count !== 16'd0) begin errors++; $display("FAIL gap_counts got bits %0d errs %0d exp 1 0", bit_count, err_count); end
    for (int i = 0; i < 20; i++) begin send(1'b0, 1'b0); if (err_pulse !== 1'b0) pulse = 1'b1; end
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL gap_pulse got 1 exp 0"); end
    checks++; if (bit_count !== 16'd21 || err_count !== 16'd0) begin errors++; $display("FAIL gap_resume got bits %0d errs %0d exp 21 0", bit_count, err_count); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 65535; i++) send(1'b0, 1'b0);
    checks++; if (bit_count !== 16'hffff) begin errors++; $display("FAIL sat_bitcnt got %0d exp 65535", bit_count); end
    send(1'b1, 1'b0);
    checks++; if (bit_count !== 16'hffff || err_count !== 16'd1) begin errors++; $display("FAIL sat_hold got bits %0d errs %0d exp 65535 1", bit_count, err_count); end
    send(1'b0, 1'b0);
  endtask

  task automatic test_reset_locked;
    logic b;
    gen(b);
    reset = 1'b1; step(1'b1, ~b, 1'b0); reset = 1'b0;
    checks++; if (locked !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("FAIL rstlock_flags got lock %0b pulse %0b exp 0 0", locked, err_pulse); end
    checks++; if (err_count !== 16'd0 || bit_count !== 16'd0) begin errors++; $display("FAIL rstlock_counts got errs %0d bits %0d exp 0 0", err_count, bit_count); end
  endtask

  task automatic test_degenerate;
    logic bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked !== 1'b0 || err_count !== 16'd0 || bit_count !== 16'd0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL zeros_lock got lock %0b errs %0d bits %0d exp 0 0 0", locked, err_count, bit_count); end
  endtask

  task automatic test_gapped;
    logic pulse = 1'b0, early = 1'b0;
    reset = 1'b1; step(1'b0, 1'b0, 1'b0); reset = 1'b0;
    g = 8'h6a;
    for (int c = 1; c <= 47; c++) begin
      if (c % 2 == 1) send(1'b0, 1'b0);
      else step(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      if (err_pulse !== 1'b0) pulse = 1'b1;
      if (c < 47 && locked !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL gapped_early got 1 exp 0"); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gapped_lock_47 got %0b exp 1", locked); end
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL gapped_pulse got 1 exp 0"); end
  endtask

  initial begin
    test_reset;
    test_clean_lock;
    test_single_error;
    test_burst;
    test_clear_priority;
    test_valid_low;
    test_saturation;
    test_reset_locked;
    test_degenerate;
    test_gapped;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs8_checker.md
PRBS8_CHECKER -- requirements
Module: prbs8_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 16: consecutive correct predictions required to declare lock.
REQ-002 Parameter UNLOCK_ERRS, default 4: consecutive mispredictions while locked that force loss of lock.
REQ-003 Parameter CNT_W, default 16: width of err_count and bit_count.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_bit is sampled only on cycles where this is 1.
REQ-007 in_bit  input  1  serial stream under test, one bit per valid cycle.
REQ-008 clear_counts  input  1  synchronous clear of err_count and bit_count.
REQ-009 locked  output  1  checker aligned to the PRBS8 stream.
REQ-010 err_pulse  output  1  one-cycle pulse per mispredicted bit while locked.
REQ-011 err_count  output  CNT_W  saturating count of mispredicted bits while locked.
REQ-012 bit_count  output  CNT_W  saturating count of valid bits checked while locked.

Function
REQ-013 Expected sequence shall obey s[n] = s[n-4] ^ s[n-5] ^ s[n-6] ^ s[n-8], the maximal-length (period 255) PRBS8 of the team's 8-bit LFSR generator, serialised from its bit 0.
REQ-014 An 8-bit history register hist shall hold the last 8 bits (hist[j] = s[n-1-j]); predicted bit = hist[7] ^ hist[5] ^ hist[4] ^ hist[3].
REQ-015 Cycles with in_valid = 0 shall change no state, no history, and no counter; err_pulse shall be 0 on the following cycle.
REQ-016 FSM states: SEARCH and LOCKED only.
REQ-017 SEARCH: each valid bit shifts in_bit into hist; a fill counter counts 0..8 and saturates at 8.
REQ-018 SEARCH: once fill = 8, each valid bit compares in_bit to the predicted bit; match increments the match counter, mismatch clears it to 0.
REQ-019 SEARCH: a match shall not count while hist = 8'h00, so an all-zero stream never locks.
REQ-020 SEARCH -> LOCKED when the match counter reaches LOCK_COUNT; locked shall be 1 on the cycle after that bit is sampled.
REQ-021 LOCKED: hist shifts in the predicted bit, not in_bit, so a single input error does not propagate.
REQ-022 LOCKED: each valid bit increments bit_count; a mismatch also increments err_count and sets err_pulse = 1 on the next cycle.
REQ-023 LOCKED: a consecutive-error counter increments on mismatch and clears on match; on reaching UNLOCK_ERRS -> SEARCH with fill, match and error-run counters cleared.
REQ-024 The bit that triggers unlock shall still be counted in err_count and bit_count and shall pulse err_pulse.
REQ-025 err_count and bit_count shall saturate at all-ones and never wrap.
REQ-026 clear_counts has priority over existing values: result = this cycle's contribution only (0 or 1).
REQ-027 clear_counts shall not affect locked, hist, or FSM state.

Reset
REQ-028 On reset = 1 at a clock edge: state = SEARCH, hist = 0, fill/match/error-run counters = 0.
REQ-029 On that same edge: locked = 0, err_pulse = 0, err_count = 0, bit_count = 0.
REQ-030 Reset applied mid-operation, including while locked, shall override all other inputs on that edge.

Verification
REQ-031 Clean lock: stream from generator seeded 8'h6a, in_valid = 1 continuously -> locked rises the cycle after the 24th bit; after 255 further bits err_count = 0 and bit_count = 255.
REQ-032 Single error: locked, invert one bit -> one err_pulse, err_count = 1, locked stays 1, and no further errors over 100 bits.
REQ-033 Burst: locked, invert 4 consecutive bits -> err_count = 4, locked falls the cycle after the 4th; it relocks 24 clean bits later.
REQ-034 Degenerate input: 300 valid zero bits after reset -> locked stays 0, and err_count and bit_count stay 0.
REQ-035 Gapped valid: in_valid alternating 1/0 with the clean stream -> lock after the 24th valid bit (47 cycles); err_pulse never asserts.
REQ-036 Clear/reset priority: clear_counts with a simultaneous error -> err_count = 1 and bit_count = 1; reset while locked -> next cycle locked = 0 and both counts = 0.
